// File: rtl/lfsrl_pkg.sv
// Shared definitions for the 13-bit Fibonacci LFSR keystream (taps 12,3,2,0, shift right).
// Used by the generator side and by lfsrl_sync_checker.
package lfsrl_pkg;

  localparam int          LFSRL_W    = 13;
  localparam logic [12:0] LFSRL_TAPS = 13'h100D;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_e;

  // One LFSR step: the feedback bit enters at the top, the state shifts right.
  function automatic logic [LFSRL_W-1:0] lfsrl_step(input logic [LFSRL_W-1:0] r);
    return {^(r & LFSRL_TAPS), r[LFSRL_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsrl_step2.sv
// Two LFSR steps per clock: next state plus the pair of bits emitted, {e1, e0}.
// Pure combinational, so the generator side can reuse it unchanged.
module lfsrl_step2
  import lfsrl_pkg::*;
(
  input  logic [LFSRL_W-1:0] state,
  output logic [LFSRL_W-1:0] next_state,
  output logic [1:0]         pair
);

  logic [LFSRL_W-1:0] step1;

  // NOTE: every output is assigned unconditionally at the top, so no latch can be inferred.
  always_comb begin
    step1      = lfsrl_step(state);
    next_state = lfsrl_step(step1);
    pair       = next_state[LFSRL_W-1 -: 2];
  end

endmodule

// File: rtl/lfsrl_sync_checker.sv
// Receive-side checker for the 2-bit-per-beat LFSR keystream: acquires, verifies, then flywheels.
// Optional LFSRL_SYNC_ZERO_GUARD_EN rejects the all-zero lockup window.
module lfsrl_sync_checker
  import lfsrl_pkg::*;
#(
  parameter int VERIFY_BEATS = 4,
  parameter int LOSS_THR     = 3,
  parameter int ERR_CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [1:0]           i_bits,
  output logic                 o_locked,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [LFSRL_W-1:0]   o_state
);

`ifdef LFSRL_SYNC_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  sync_state_e        state;
  logic [2:0]         beat_cnt;
  logic [3:0]         run_cnt;
  logic [3:0]         miss_cnt;
  logic [LFSRL_W-1:0] fly_window;
  logic [LFSRL_W-1:0] rx_window;
  logic [1:0]         expected;
  logic               mismatch;

  lfsrl_step2 u_step2 (
    .state      (o_state),
    .next_state (fly_window),
    .pair       (expected)
  );

  assign rx_window = {i_bits, o_state[LFSRL_W-1:2]};
  assign mismatch  = (i_bits != expected);

  // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values.
  // NOTE: the async reset clears every flop, including the window, so no X escapes after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ACQ;
      beat_cnt  <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      o_state   <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else if (i_clr) begin
      state     <= ACQ;
      beat_cnt  <= '0;
      run_cnt   <= '0;
      miss_cnt  <= '0;
      o_state   <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_valid) begin
        unique case (state)
          ACQ: begin
            o_state <= rx_window;
            if (beat_cnt == 3'd6) begin
              beat_cnt <= '0;
              if (!(ZERO_GUARD && rx_window == '0)) begin
                state   <= VERIFY;
                run_cnt <= '0;
              end
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
          VERIFY: begin
            o_state <= rx_window;
            if (mismatch) begin
              o_err    <= 1'b1;
              state    <= ACQ;
              beat_cnt <= '0;
            end else if (run_cnt == 4'(VERIFY_BEATS - 1)) begin
              state    <= LOCK;
              o_locked <= 1'b1;
              miss_cnt <= '0;
            end else begin
              run_cnt <= run_cnt + 4'd1;
            end
          end
          LOCK: begin
            // Flywheel: the window follows the prediction, so a bad beat never enters it.
            o_state <= fly_window;
            if (mismatch) begin
              o_err <= 1'b1;
              if (!(&o_err_cnt)) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
              miss_cnt <= miss_cnt + 4'd1;
            end else begin
              miss_cnt <= '0;
            end
            if ((mismatch && miss_cnt == 4'(LOSS_THR - 1)) ||
                (ZERO_GUARD && fly_window == '0)) begin
              state    <= ACQ;
              o_locked <= 1'b0;
              beat_cnt <= '0;
            end
          end
          default: begin
            state    <= ACQ;
            o_locked <= 1'b0;
            beat_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsrl_sync_checker.sv
// Self-checking bench for lfsrl_sync_checker: bit-sequence reference model, randomized stream.
// Honours LFSRL_SYNC_ZERO_GUARD_EN when the design is built with it.
module tb_lfsrl_sync_checker;

`ifdef LFSRL_SYNC_ZERO_GUARD_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_bits = 2'b00;
  logic        o_locked, o_err, s_locked, s_err;
  logic [15:0] o_err_cnt;
  logic [1:0]  s_err_cnt;
  logic [12:0] o_state, s_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  lfsrl_sync_checker dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_valid(i_valid), .i_bits(i_bits),
    .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt), .o_state(o_state)
  );

  lfsrl_sync_checker #(.ERR_CNT_W(2)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(i_clr), .i_valid(i_valid), .i_bits(i_bits),
    .o_locked(s_locked), .o_err(s_err), .o_err_cnt(s_err_cnt), .o_state(s_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Keystream recurrence: b(m) = b(m-1) ^ b(m-10) ^ b(m-11) ^ b(m-13); q holds the last 13 bits, oldest first.
  function automatic bit next_bit(input bit q[$]);
    return q[12] ^ q[3] ^ q[2] ^ q[0];
  endfunction

  function automatic logic [12:0] pack(input bit q[$]);
    logic [12:0] p;
    for (int k = 0; k < 13; k++) p[k] = q[k];
    return p;
  endfunction

  function automatic bit all_zero(input bit q[$]);
    for (int k = 0; k < 13; k++) if (q[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sat(input int c, input int cap);
    return (c > cap) ? cap : c;
  endfunction

  // Reference model: mode 0 = acquiring, 1 = verifying, 2 = locked.
  bit hist[$];
  int m_mode, m_beats, m_run, m_miss, m_cnt;
  bit m_err;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 13; k++) hist.push_back(1'b0);
    m_mode = 0; m_beats = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit clr, input bit v, input logic [1:0] b);
    bit e0, e1, mis;
    bit t[$];
    m_err = 1'b0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      e0 = next_bit(hist);
      t = hist; t.push_back(e0); void'(t.pop_front());
      e1 = next_bit(t);
      mis = (b != {e1, e0});
      if (m_mode == 2) begin
        hist.push_back(e0); hist.push_back(e1);
      end else begin
        hist.push_back(b[0]); hist.push_back(b[1]);
      end
      void'(hist.pop_front()); void'(hist.pop_front());
      case (m_mode)
        0: begin
          m_beats++;
          if (m_beats == 7) begin
            m_beats = 0;
            if (!(ZG && all_zero(hist))) begin m_mode = 1; m_run = 0; end
          end
        end
        1: begin
          if (mis) begin m_err = 1'b1; m_mode = 0; m_beats = 0; end
          else begin
            m_run++;
            if (m_run == 4) begin m_mode = 2; m_miss = 0; end
          end
        end
        default: begin
          if (mis) begin
            m_err = 1'b1; m_cnt++; m_miss++;
            if (m_miss == 3) begin m_mode = 0; m_beats = 0; end
          end else m_miss = 0;
          if (ZG && all_zero(hist)) begin m_mode = 0; m_beats = 0; end
        end
      endcase
    end
  endtask

  task automatic compare_all();
    check("locked", o_locked, (m_mode == 2));
    check("err", o_err, m_err);
    check("err_cnt", o_err_cnt, sat(m_cnt, 65535));
    check("state", o_state, pack(hist));
    check("sat_locked", s_locked, (m_mode == 2));
    check("sat_err_cnt", s_err_cnt, sat(m_cnt, 3));
    check("sat_state", s_state, pack(hist));
  endtask

  // Generator: bit sequence seeded from a 13-bit state, two bits emitted per beat.
  bit gq[$];

  task automatic gen_seed(input logic [12:0] s);
    gq.delete();
    for (int k = 0; k < 13; k++) gq.push_back(s[k]);
  endtask

  task automatic gen_beat(output logic [1:0] b);
    b = {gq[1], gq[0]};
    repeat (2) begin
      gq.push_back(next_bit(gq));
      void'(gq.pop_front());
    end
  endtask

  task automatic cycle(input bit clr, input bit v, input logic [1:0] b);
    i_clr = clr; i_valid = v; i_bits = b;
    @(posedge i_clk);
    model_step(clr, v, b);
    #1;
    compare_all();
    i_clr = 1'b0; i_valid = 1'b0;
  endtask

  // One generator beat, optionally corrupted by an XOR mask.
  task automatic send(input logic [1:0] flip);
    logic [1:0] b;
    gen_beat(b);
    cycle(1'b0, 1'b1, b ^ flip);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'($urandom_range(3)));
  endtask

  task automatic async_reset();
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_locked", o_locked, 0);
    check("rst_state", o_state, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] flip;
    int beats;

    model_reset();
    #3;
    compare_all();
    @(negedge i_clk) i_rst_n = 1'b1;

    // Clean lock from seed 1.
    gen_seed(13'h0001);
    repeat (7) send(2'b00);
    check("acq_full_state", o_state, 13'h1000);
    check("verify_unlocked", o_locked, 0);
    repeat (3) send(2'b00);
    check("unlocked_b10", o_locked, 0);
    send(2'b00);
    check("locked_b11", o_locked, 1);
    beats = 0;
    while (beats < 1000) begin
      if ($urandom_range(3) != 0) begin send(2'b00); beats++; end
      else idle();
    end
    check("clean_err_cnt", o_err_cnt, 0);

    // Single error in lock: flywheel keeps the window clean.
    send(2'b01);
    check("single_err_pulse", o_err, 1);
    check("single_err_cnt", o_err_cnt, 1);
    check("single_lock_held", o_locked, 1);
    repeat (5) send(2'b00);
    check("single_after_cnt", o_err_cnt, 1);

    // Burst of three bad beats drops lock (count includes the earlier single error).
    repeat (2) send(2'($urandom_range(1, 3)));
    check("burst_still_locked", o_locked, 1);
    send(2'($urandom_range(1, 3)));
    check("burst_lock_lost", o_locked, 0);
    check("burst_err_cnt", o_err_cnt, 4);
    repeat (10) send(2'b00);
    check("relock_early", o_locked, 0);
    send(2'b00);
    check("relock", o_locked, 1);

    // Async reset mid-lock, then a VERIFY failure on beat 9 with a random seed.
    async_reset();
    gen_seed(13'($urandom_range(1, 8191)));
    repeat (8) send(2'b00);
    send(2'($urandom_range(1, 3)));
    check("verify_fail_pulse", o_err, 1);
    check("verify_fail_cnt", o_err_cnt, 0);
    repeat (10) send(2'b00);
    check("verify_b19", o_locked, 0);
    send(2'b00);
    check("verify_lock_b20", o_locked, 1);

    // Five isolated errors saturate the 2-bit counter; clear wins over a valid beat.
    repeat (5) begin
      send(2'b10);
      repeat (3) send(2'b00);
    end
    check("sat_cnt", s_err_cnt, 3);
    check("wide_cnt", o_err_cnt, 5);
    cycle(1'b1, 1'b1, 2'b11);
    check("clr_cnt", o_err_cnt, 0);
    check("clr_sat_cnt", s_err_cnt, 0);
    check("clr_unlocked", o_locked, 0);
    check("clr_beat_dropped", o_state, 0);

    // Randomized stream: gaps, sporadic corruption, rare clears.
    gen_seed(13'($urandom_range(1, 8191)));
    repeat (1500) begin
      if ($urandom_range(199) == 0) cycle(1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)));
      else if ($urandom_range(3) == 0) idle();
      else begin
        flip = ($urandom_range(15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        send(flip);
      end
    end

    // All-zero stream: locks only without the zero guard.
    async_reset();
    repeat (11) cycle(1'b0, 1'b1, 2'b00);
    check("zero_b11", o_locked, ZG ? 0 : 1);
    repeat (9) cycle(1'b0, 1'b1, 2'b00);
    check("zero_b20", o_locked, ZG ? 0 : 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
